// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - job, operand handshake and DSP48A1 control bundle for the MAC sequencer
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             cfg_preadd;
    logic             cfg_presub;
    logic             in_valid;
    logic             in_ready;
    logic             CE_IN;
    logic             CE_MID;
    logic             CEM;
    logic             CEP;
    logic             RSTP;
    logic [7:0]       OPMODE;
    logic             busy;
    logic             result_valid;

    modport master (
        output start, len, cfg_preadd, cfg_presub, in_valid,
        input  in_ready, CE_IN, CE_MID, CEM, CEP, RSTP, OPMODE, busy, result_valid
    );

    modport slave (
        input  start, len, cfg_preadd, cfg_presub, in_valid,
        output in_ready, CE_IN, CE_MID, CEM, CEP, RSTP, OPMODE, busy, result_valid
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - dot-product sequencer driving DSP48A1 CE/OPMODE/RSTP controls
module dsp_mac_sequencer #(
    parameter int LEN_W     = 8,
    parameter int AB_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    dsp_mac_sequencer_if.slave  bus
);
    localparam int LAT = AB_STAGES + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLR} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issued;
    logic               preadd_q;
    logic               presub_q;
    logic               clr_done;
    logic [LAT-1:0]     vld;
    logic [LAT-1:0]     last_tag;
    logic [AB_STAGES:0] first_tag;

    logic run_ready;
    logic accept;
    logic last_beat;
    logic first_beat;
    logic done;
    logic z_zero;
    logic job_active;

    assign run_ready  = (state == RUN) && (issued != len_q);
    assign accept     = bus.in_valid & run_ready;
    assign last_beat  = (issued == len_q - LEN_W'(1));
    assign first_beat = (issued == '0);
    // A len==0 job finishes through clr_done, never through the beat pipeline.
    assign done       = (vld[LAT-1] & last_tag[LAT-1]) | clr_done;
    // The first product of a job must overwrite P rather than accumulate stale contents.
    assign z_zero     = vld[AB_STAGES] & first_tag[AB_STAGES];
    assign job_active = (state != IDLE);

    assign bus.in_ready     = run_ready;
    assign bus.CE_IN        = accept;
    assign bus.CEM          = vld[AB_STAGES-1];
    assign bus.CEP          = vld[AB_STAGES];
    assign bus.RSTP         = (state == CLR);
    assign bus.busy         = job_active;
    assign bus.result_valid = done;
    assign bus.OPMODE       = job_active ?
                              {1'b0, presub_q, 1'b0, preadd_q, (z_zero ? 2'b00 : 2'b10), 2'b01} :
                              8'h00;

    generate
        if (AB_STAGES == 2) begin : g_mid
            assign bus.CE_MID = vld[0];
        end else begin : g_no_mid
            assign bus.CE_MID = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? CLR : RUN;
            RUN:     if (accept && last_beat) state_nxt = DRAIN;
            DRAIN:   if (done) state_nxt = IDLE;
            CLR:     state_nxt = DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            len_q     <= '0;
            issued    <= '0;
            preadd_q  <= 1'b0;
            presub_q  <= 1'b0;
            clr_done  <= 1'b0;
            vld       <= '0;
            last_tag  <= '0;
            first_tag <= '0;
        end else begin
            state     <= state_nxt;
            clr_done  <= (state == CLR);
            vld       <= {vld[LAT-2:0], accept};
            last_tag  <= {last_tag[LAT-2:0], accept & last_beat};
            first_tag <= {first_tag[AB_STAGES-1:0], accept & first_beat};
            if (state == IDLE && bus.start) begin
                len_q    <= bus.len;
                preadd_q <= bus.cfg_preadd;
                presub_q <= bus.cfg_presub;
                issued   <= '0;
            end else if (accept) begin
                issued <= issued + LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - randomized self-checking bench with a behavioural DSP48A1 slice and dot-product reference
module tb_dsp_mac_sequencer;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dsp_mac_sequencer_if #(.LEN_W(8)) bus ();

    dsp_mac_sequencer #(.LEN_W(8), .AB_STAGES(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int in_a, in_b, in_d;
    int a1, b1, d1, a2, b2, d2;
    longint m_reg, p_reg;

    // Slice stand-in: the controls decide what each register captures.
    always @(posedge CLK) begin
        if (bus.CE_IN) begin a1 <= in_a; b1 <= in_b; d1 <= in_d; end
        if (bus.CE_MID) begin a2 <= a1; b2 <= b1; d2 <= d1; end
        if (bus.CEM)
            m_reg <= longint'(a2) * longint'(bus.OPMODE[4] ? (bus.OPMODE[6] ? d2 - b2 : d2 + b2) : b2);
        if (bus.RSTP)
            p_reg <= 0;
        else if (bus.CEP)
            p_reg <= ((bus.OPMODE[3:2] == 2'b00) ? 64'sd0 : p_reg) + m_reg;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    int ba[$];
    int bb[$];
    int bd[$];
    int vpat[$];

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".in_ready"}, longint'(bus.in_ready), 0);
        chk({tag, ".ce"}, longint'({bus.CE_IN, bus.CE_MID, bus.CEM, bus.CEP, bus.RSTP}), 0);
        chk({tag, ".opmode"}, longint'(bus.OPMODE), 0);
        chk({tag, ".busy"}, longint'(bus.busy), 0);
        chk({tag, ".result_valid"}, longint'(bus.result_valid), 0);
    endtask

    task automatic run_job(input string name, input int n, input bit pre, input bit sub,
                           input int vmode, input bit inject, input bit abort);
        longint exp_sum = 0;
        int k = 0, cyc = 0, pi = 0, last_cyc = -1, rv_cyc = -1;
        int nce = 0, ncem = 0, ncep = 0, nrstp = 0, bad_mode = 0, not_busy = 0, rv_seen = 0;
        bit done = 0;
        bit vo;
        longint p_at_rv = 0;
        for (int i = 0; i < n; i++)
            exp_sum += longint'(ba[i]) * longint'(pre ? (sub ? bd[i] - bb[i] : bd[i] + bb[i]) : bb[i]);

        bus.start = 1'b1; bus.len = 8'(n); bus.cfg_preadd = pre; bus.cfg_presub = sub;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        while (!done && cyc < 300) begin
            if (k < n) begin
                case (vmode)
                    0:       vo = 1'b1;
                    1:       vo = (pi < vpat.size()) ? vpat[pi][0] : 1'b1;
                    default: vo = ($urandom_range(0, 9) < 6);
                endcase
                pi++;
                in_a = ba[k]; in_b = bb[k]; in_d = bd[k];
            end else begin
                vo = 1'b0;
            end
            bus.in_valid = vo;
            if (inject && cyc == 1) begin bus.start = 1'b1; bus.len = 8'd9; end
            else bus.start = 1'b0;
            #1;
            if (bus.CE_IN) nce++;
            if (bus.CEM) ncem++;
            if (bus.RSTP) nrstp++;
            if (bus.CEP) begin
                chk($sformatf("%s.z_sel%0d", name, ncep), longint'(bus.OPMODE[3:2]), (ncep == 0) ? 0 : 2);
                chk($sformatf("%s.x_sel%0d", name, ncep), longint'(bus.OPMODE[1:0]), 1);
                ncep++;
            end
            if (bus.busy && (bus.OPMODE[4] != pre || bus.OPMODE[6] != sub || bus.OPMODE[5] || bus.OPMODE[7]))
                bad_mode++;
            if (!bus.busy) not_busy++;
            if (bus.in_valid && bus.in_ready) begin
                k++;
                if (k == n) last_cyc = cyc;
            end
            if (bus.result_valid) begin
                done = 1; rv_cyc = cyc; p_at_rv = p_reg;
            end
            if (abort && n > 0 && k == n && cyc == last_cyc + 2) begin
                bus.in_valid = 1'b0;
                RST = 1'b1;
                @(posedge CLK); #1;
                RST = 1'b0;
                #1;
                check_idle_outputs({name, ".after_rst"});
                for (int i = 0; i < 10; i++) begin
                    @(posedge CLK); #2;
                    if (bus.result_valid) rv_seen++;
                end
                chk({name, ".no_result_after_rst"}, rv_seen, 0);
                return;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        chk({name, ".completed"}, longint'(done), 1);
        chk({name, ".p"}, p_at_rv, exp_sum);
        chk({name, ".ce_in_count"}, nce, n);
        chk({name, ".cem_count"}, ncem, n);
        chk({name, ".cep_count"}, ncep, n);
        chk({name, ".rstp_count"}, nrstp, (n == 0) ? 1 : 0);
        chk({name, ".mode_stable"}, bad_mode, 0);
        chk({name, ".busy_held"}, not_busy, 0);
        if (n > 0) chk({name, ".latency"}, rv_cyc - last_cyc, 4);
        else       chk({name, ".clr_latency"}, rv_cyc, 1);
        #1;
        chk({name, ".rv_width"}, longint'(bus.result_valid), 0);
        chk({name, ".idle_after"}, longint'(bus.busy), 0);
    endtask

    task automatic fill_random(input int n);
        ba.delete(); bb.delete(); bd.delete();
        for (int i = 0; i < n; i++) begin
            ba.push_back(int'($urandom_range(0, 200)) - 100);
            bb.push_back(int'($urandom_range(0, 200)) - 100);
            bd.push_back(int'($urandom_range(0, 200)) - 100);
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.cfg_preadd = 1'b0; bus.cfg_presub = 1'b0; bus.in_valid = 1'b0;
        in_a = 0; in_b = 0; in_d = 0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        #1 check_idle_outputs("reset");

        ba = '{1, 2, 3, 4}; bb = '{5, 6, 7, 8}; bd = '{0, 0, 0, 0};
        run_job("n4_full", 4, 0, 0, 0, 0, 0);

        fill_random(3);
        vpat = '{1, 0, 0, 1, 0, 1};
        run_job("n3_gaps", 3, 0, 0, 1, 0, 0);

        run_job("len0", 0, 0, 0, 0, 0, 0);

        ba = '{3}; bb = '{2}; bd = '{10};
        run_job("preadd", 1, 1, 0, 0, 0, 0);

        fill_random(5);
        run_job("abort", 5, 0, 0, 0, 0, 1);
        fill_random(2);
        run_job("after_abort", 2, 0, 1, 2, 0, 0);

        fill_random(5);
        run_job("start_busy", 5, 0, 0, 0, 1, 0);

        for (int j = 0; j < 6; j++) begin
            int n = int'($urandom_range(1, 12));
            fill_random(n);
            run_job($sformatf("rand%0d", j), n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
